iterative_addsub_seq: RTL and testbench

- Multi-cycle, block-serial N-bit adder/subtractor that reuses one X-bit ripple-carry slice.
- Processes one X-bit block per clock, LSB block first, carrying between cycles in a register.
- Trades latency for area against the fully unrolled combinational iterative adder.
- Sits in the FPU datapath where mantissa/exponent add/sub can tolerate multi-cycle latency.
- Valid/ready handshake on both input and output.

---
 rtl/iterative_addsub_seq_pkg.sv | 15 +
 rtl/iterative_addsub_seq_if.sv | 24 ++
 rtl/iterative_addsub_seq_rca.sv | 23 ++
 rtl/iterative_addsub_seq.sv | 107 ++++++++++
 tb/tb_iterative_addsub_seq.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/iterative_addsub_seq_pkg.sv
// Shared definitions for the block-serial adder/subtractor: FSM state type and
// the block-count helper used to size the iteration.
package iterative_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int unsigned num_blocks(input int unsigned n, input int unsigned x);
    return (n + x - 1) / x;
  endfunction

endpackage

// File: rtl/iterative_addsub_seq_if.sv
// Valid/ready operand and result channel of the block-serial adder/subtractor.
interface iterative_addsub_seq_if #(parameter int unsigned N = 16);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] S;
  logic         Cout;
  logic         Ovf;

  modport master (
    output in_valid, A, B, Cin, sub, out_ready,
    input  in_ready, out_valid, S, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, sub, out_ready,
    output in_ready, out_valid, S, Cout, Ovf
  );
endinterface

// File: rtl/iterative_addsub_seq_rca.sv
// Plain N-bit ripple-carry adder; used as the per-cycle slice.
module rca #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout
);
  logic [N:0] c;

  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = Cin;
    for (int unsigned i = 0; i < N; i++) begin
      S[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    Cout = c[N];
  end
endmodule

// File: rtl/iterative_addsub_seq.sv
// Multi-cycle N-bit adder/subtractor: one X-bit ripple slice reused per clock,
// LSB block first, with the inter-block carry held in a register.
module iterative_addsub_seq
  import iterative_adder_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned X = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  rst_n,
  iterative_addsub_seq_if.slave bus
);
  localparam int unsigned XE         = (X >= N) ? N : X;
  localparam int unsigned NUM_BLOCKS = num_blocks(N, XE);
  localparam int unsigned PW         = NUM_BLOCKS * XE;
  // Position of the true carry-out inside the (possibly zero-padded) last slice.
  localparam int unsigned R          = N - (NUM_BLOCKS - 1) * XE;
  localparam int unsigned KW         = $clog2(NUM_BLOCKS + 1);

  state_t          state_q;
  logic [PW-1:0]   a_q, b_q;
  logic [N-1:0]    s_q, s_d;
  logic            carry_q, cout_q, ovf_q, a_msb_q, b_msb_q, out_valid_q;
  logic [KW-1:0]   k_q;

  logic [N-1:0]    b_eff;
  logic [XE-1:0]   slice_a, slice_b, slice_s;
  logic            slice_co;
  logic [XE:0]     slice_full;
  logic            last_blk;

  assign b_eff      = bus.sub ? ~bus.B : bus.B;
  assign slice_a    = a_q[k_q*XE +: XE];
  assign slice_b    = b_q[k_q*XE +: XE];
  assign slice_full = {slice_co, slice_s};
  assign last_blk   = (k_q == KW'(NUM_BLOCKS - 1));

  rca #(.N(XE)) u_slice (
    .A    (slice_a),
    .B    (slice_b),
    .Cin  (carry_q),
    .S    (slice_s),
    .Cout (slice_co)
  );

  // Only bits below N are written, so padded sum bits never reach S.
  always_comb begin
    s_d = s_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (KW'(i / XE) == k_q) s_d[i] = slice_s[i % XE];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      carry_q     <= 1'b0;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q     <= PW'(bus.A);
            b_q     <= PW'(b_eff);
            carry_q <= bus.sub ? ~bus.Cin : bus.Cin;
            a_msb_q <= bus.A[N-1];
            b_msb_q <= b_eff[N-1];
            k_q     <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          s_q     <= s_d;
          carry_q <= slice_co;
          k_q     <= k_q + KW'(1);
          if (last_blk) begin
            cout_q      <= slice_full[R];
            ovf_q       <= (a_msb_q == b_msb_q) & (slice_full[R-1] != a_msb_q);
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;
  assign bus.Ovf       = ovf_q;
endmodule

// File: tb/tb_iterative_addsub_seq.sv
// Directed bench for iterative_addsub_seq: a 16-bit/4-bit instance and a
// 10-bit/4-bit instance (partial last block) sharing clock and reset.
module tb_iterative_addsub_seq;
  logic CLOCK_50 = 1'b0;
  logic rst_n    = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  iterative_addsub_seq_if #(.N(16)) if16 ();
  iterative_addsub_seq_if #(.N(10)) if10 ();

  iterative_addsub_seq #(.N(16), .X(4)) dut16 (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .bus      (if16.slave)
  );

  iterative_addsub_seq #(.N(10), .X(4)) dut10 (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .bus      (if10.slave)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drive(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sb, input logic v);
    if (sel == 0) begin
      if16.A = a; if16.B = b; if16.Cin = cin; if16.sub = sb; if16.in_valid = v;
    end else begin
      if10.A = a[9:0]; if10.B = b[9:0]; if10.Cin = cin; if10.sub = sb; if10.in_valid = v;
    end
  endtask

  task automatic set_oready(input int sel, input logic v);
    if (sel == 0) if16.out_ready = v;
    else          if10.out_ready = v;
  endtask

  function automatic logic [31:0] get_s(input int sel);
    return (sel == 0) ? 32'(if16.S) : 32'(if10.S);
  endfunction
  function automatic logic [31:0] get_c(input int sel);
    return (sel == 0) ? 32'(if16.Cout) : 32'(if10.Cout);
  endfunction
  function automatic logic [31:0] get_o(input int sel);
    return (sel == 0) ? 32'(if16.Ovf) : 32'(if10.Ovf);
  endfunction
  function automatic logic [31:0] get_v(input int sel);
    return (sel == 0) ? 32'(if16.out_valid) : 32'(if10.out_valid);
  endfunction
  function automatic logic [31:0] get_r(input int sel);
    return (sel == 0) ? 32'(if16.in_ready) : 32'(if10.in_ready);
  endfunction

  // Accept one operation, check exact latency, result, then pop it.
  task automatic run_op(input string tag, input int sel, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sb, input logic [15:0] es,
                        input logic ec, input logic eo);
    int nb;
    nb = (sel == 0) ? 4 : 3;
    check({tag, " in_ready idle"}, get_r(sel), 32'd1);
    drive(sel, a, b, cin, sb, 1'b1);
    tick();
    drive(sel, a, b, cin, sb, 1'b0);
    for (int i = 1; i <= nb; i++) begin
      check($sformatf("%s out_valid early %0d", tag, i), get_v(sel), 32'd0);
      check($sformatf("%s in_ready busy %0d", tag, i), get_r(sel), 32'd0);
      tick();
    end
    check({tag, " out_valid"}, get_v(sel), 32'd1);
    check({tag, " S"}, get_s(sel), 32'(es));
    check({tag, " Cout"}, get_c(sel), 32'(ec));
    check({tag, " Ovf"}, get_o(sel), 32'(eo));
    set_oready(sel, 1'b1);
    tick();
    set_oready(sel, 1'b0);
    check({tag, " out_valid drop"}, get_v(sel), 32'd0);
    check({tag, " in_ready back"}, get_r(sel), 32'd1);
  endtask

  initial begin
    drive(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    drive(1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    set_oready(0, 1'b0);
    set_oready(1, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    check("reset out_valid", get_v(0), 32'd0);
    check("reset S", get_s(0), 32'd0);
    check("reset Cout", get_c(0), 32'd0);
    check("reset Ovf", get_o(0), 32'd0);
    check("reset in_ready", get_r(0), 32'd1);
    check("reset10 S", get_s(1), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("add basic", 0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_op("add wrap", 0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add ovf", 0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub borrow", 0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub ovf", 0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub borrow-in", 0, 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);

    // Backpressure: result held in DONE while a competing operation is presented.
    drive(0, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b1);
    tick();
    drive(0, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    drive(0, 16'h4000, 16'h4000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp out_valid %0d", i), get_v(0), 32'd1);
      check($sformatf("bp S %0d", i), get_s(0), 32'hFFFF);
      check($sformatf("bp Cout %0d", i), get_c(0), 32'd0);
      check($sformatf("bp Ovf %0d", i), get_o(0), 32'd0);
      check($sformatf("bp in_ready %0d", i), get_r(0), 32'd0);
      tick();
    end
    set_oready(0, 1'b1);
    tick();
    set_oready(0, 1'b0);
    check("bp release out_valid", get_v(0), 32'd0);
    check("bp release in_ready", get_r(0), 32'd1);
    tick();
    drive(0, 16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0);
    check("bp accept in_ready", get_r(0), 32'd0);
    repeat (3) tick();
    check("bp op2 not yet valid", get_v(0), 32'd0);
    tick();
    check("bp op2 out_valid", get_v(0), 32'd1);
    check("bp op2 S", get_s(0), 32'h8000);
    check("bp op2 Cout", get_c(0), 32'd0);
    check("bp op2 Ovf", get_o(0), 32'd1);
    set_oready(0, 1'b1);
    tick();
    set_oready(0, 1'b0);

    // Reset while RUN is on block k=2.
    drive(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    tick();
    drive(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst out_valid", get_v(0), 32'd0);
    check("midrst S", get_s(0), 32'd0);
    check("midrst Cout", get_c(0), 32'd0);
    check("midrst in_ready", get_r(0), 32'd1);
    tick();
    check("midrst no output", get_v(0), 32'd0);
    run_op("after rst", 0, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Partial last block: N=10, X=4 -> 3 RUN cycles.
    run_op("n10 wrap", 1, 16'h03FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("n10 cin", 1, 16'h0155, 16'h00AA, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b1);
    run_op("n10 sub", 1, 16'h0003, 16'h0005, 1'b0, 1'b1, 16'h03FE, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
